// File: rtl/ddr_burst_fetcher_if.sv
// Bus bundle between the burst fetcher, the DDR read port and the downstream
// queue. The master side is the fetcher; the slave side is the memory/queue.
//
// Handshake rules:
//   - DDR request: ddr_rd is held with ddr_addr/ddr_burst_length stable until
//     the cycle where ddr_rd & ~ddr_wait_req; that cycle is the accept.
//   - DDR data: each cycle with ddr_valid high carries one beat; there is no
//     back-pressure on read data.
//   - Queue: enq_valid is a one-cycle enqueue strobe with no ready; the fetcher
//     only requests a burst when the queue has room for all of its beats.
interface ddr_burst_fetcher_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int COUNT_WIDTH = 6
);
    // DDR read port
    logic                   ddr_rd;
    logic [ADDR_WIDTH-1:0]  ddr_addr;
    logic [7:0]             ddr_burst_length;
    logic                   ddr_wait_req;
    logic                   ddr_valid;
    logic [DATA_WIDTH-1:0]  ddr_data;

    // Downstream queue
    logic [COUNT_WIDTH-1:0] queue_count;
    logic                   queue_flush;
    logic                   enq_valid;
    logic [DATA_WIDTH-1:0]  enq_bits;

    modport master (
        output ddr_rd,
        output ddr_addr,
        output ddr_burst_length,
        input  ddr_wait_req,
        input  ddr_valid,
        input  ddr_data,
        input  queue_count,
        output queue_flush,
        output enq_valid,
        output enq_bits
    );

    modport slave (
        input  ddr_rd,
        input  ddr_addr,
        input  ddr_burst_length,
        output ddr_wait_req,
        output ddr_valid,
        output ddr_data,
        output queue_count,
        input  queue_flush,
        input  enq_valid,
        input  enq_bits
    );
endinterface

// File: rtl/ddr_burst_fetcher.sv
// Burst fetcher: reads a linear DDR region in bursts of up to BURST_LEN beats
// and pushes every beat into the downstream queue. A burst is only requested
// once the queue has room for all of its beats, so the queue needs no ready.
module ddr_burst_fetcher #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int BURST_LEN   = 16,
    parameter int DEPTH       = 32,
    parameter int COUNT_WIDTH = 6,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  num_words,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            state_dbg,
    ddr_burst_fetcher_if.master   bus
);

    localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
    localparam int BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);
    localparam int SUM_WIDTH      = LEN_WIDTH + 2;

    localparam logic [LEN_WIDTH-1:0] BURST_LEN_L = LEN_WIDTH'(BURST_LEN);
    localparam logic [SUM_WIDTH-1:0] DEPTH_L     = SUM_WIDTH'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_CHECK = 3'd2,
        S_REQ   = 3'd3,
        S_RECV  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                  state_q;
    state_t                  state_d;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LEN_WIDTH-1:0]    remaining_q;
    logic [LEN_WIDTH-1:0]    beat_cnt_q;
    logic                    enq_valid_q;
    logic [DATA_WIDTH-1:0]   enq_bits_q;

    logic [LEN_WIDTH-1:0]    len_cur;
    logic [SUM_WIDTH-1:0]    used_plus_len;
    logic                    room_ok;
    logic                    accept;
    logic                    beat_in;
    logic                    last_beat;

    // Burst sizing and flow-control terms shared by the FSM and datapath.
    // A beat sitting in the enqueue register has not reached queue_count yet,
    // so it is counted as occupied when judging free space.
    always_comb begin
        len_cur       = (remaining_q > BURST_LEN_L) ? BURST_LEN_L : remaining_q;
        used_plus_len = SUM_WIDTH'(bus.queue_count) + SUM_WIDTH'(enq_valid_q)
                      + SUM_WIDTH'(len_cur);
        room_ok       = (used_plus_len <= DEPTH_L);
        accept        = (state_q == S_REQ) && !bus.ddr_wait_req;
        beat_in       = (state_q == S_RECV) && bus.ddr_valid;
        last_beat     = beat_in && (beat_cnt_q == LEN_WIDTH'(1));
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = (remaining_q == '0) ? S_DONE : S_CHECK;
            end
            S_CHECK: begin
                if (room_ok) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (accept) begin
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                // remaining was already reduced when this burst was accepted.
                if (last_beat) begin
                    state_d = (remaining_q != '0) ? S_CHECK : S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Transfer bookkeeping: address, beats still to request, beats still to receive.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q      <= base_addr;
                        remaining_q <= num_words;
                    end
                end
                S_REQ: begin
                    if (accept) begin
                        // Wraps naturally at 2^ADDR_WIDTH.
                        addr_q      <= addr_q + (ADDR_WIDTH'(len_cur) << BEAT_SHIFT);
                        remaining_q <= remaining_q - len_cur;
                        beat_cnt_q  <= len_cur;
                    end
                end
                S_RECV: begin
                    if (beat_in) begin
                        beat_cnt_q <= beat_cnt_q - LEN_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Enqueue register: one cycle from DDR beat to queue strobe; data outside RECV is dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enq_valid_q <= 1'b0;
            enq_bits_q  <= '0;
        end else begin
            enq_valid_q <= beat_in;
            if (beat_in) begin
                enq_bits_q <= bus.ddr_data;
            end
        end
    end

    // Status and bus outputs decoded from state; request fields are zero outside REQ.
    always_comb begin
        busy                 = (state_q != S_IDLE) && (state_q != S_DONE);
        done                 = (state_q == S_DONE);
        state_dbg            = state_q;
        bus.queue_flush      = (state_q == S_FLUSH);
        bus.ddr_rd           = (state_q == S_REQ);
        bus.ddr_addr         = (state_q == S_REQ) ? addr_q : '0;
        bus.ddr_burst_length = (state_q == S_REQ) ? 8'(len_cur) : 8'd0;
        bus.enq_valid        = enq_valid_q;
        bus.enq_bits         = enq_bits_q;
    end

endmodule

// File: tb/tb_ddr_burst_fetcher.sv
// Testbench for ddr_burst_fetcher: directed transfers with expected DDR
// requests and enqueue beats queued up front and checked by a monitor.
module tb_ddr_burst_fetcher;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] num_words;
    logic        busy;
    logic        done;
    logic [2:0]  state_dbg;

    ddr_burst_fetcher_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .COUNT_WIDTH(6)) bus_if ();

    ddr_burst_fetcher #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .BURST_LEN(16),
        .DEPTH(32), .COUNT_WIDTH(6), .LEN_WIDTH(16)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg),
        .bus       (bus_if)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    logic [63:0] exp_q[$];
    logic [39:0] exp_req_q[$];
    int checks = 0;
    int errors = 0;
    int enq_seen = 0;
    int acc_cnt = 0;
    int rd_cycles = 0;
    int flush_cnt = 0;
    int done_cnt = 0;
    int beats_left = 0;
    logic [31:0] beat_addr = '0;
    bit inject_valid = 1'b0;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'h5A5A_5A5A, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_ctl"}, 64'({busy, done, bus_if.ddr_rd, bus_if.queue_flush, bus_if.enq_valid}), 64'd0);
        check({name, "_addr"}, 64'(bus_if.ddr_addr), 64'd0);
        check({name, "_len"}, 64'(bus_if.ddr_burst_length), 64'd0);
        check({name, "_bits"}, bus_if.enq_bits, 64'd0);
        check({name, "_state"}, 64'(state_dbg), 64'd0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (reset_n) begin
            if (bus_if.enq_valid) begin
                enq_seen++;
                if (exp_q.size() == 0) begin
                    check("enq_unexpected", bus_if.enq_bits, 64'hx);
                end else begin
                    check("enq_data", bus_if.enq_bits, exp_q.pop_front());
                end
            end
            if (bus_if.ddr_rd) rd_cycles++;
            if (bus_if.ddr_rd && !bus_if.ddr_wait_req) begin
                acc_cnt++;
                if (exp_req_q.size() == 0) begin
                    check("req_unexpected", {24'd0, bus_if.ddr_addr, bus_if.ddr_burst_length}, 64'hx);
                end else begin
                    check("req_addr_len", {24'd0, bus_if.ddr_addr, bus_if.ddr_burst_length},
                          {24'd0, exp_req_q.pop_front()});
                end
                beats_left = int'(bus_if.ddr_burst_length);
                beat_addr  = bus_if.ddr_addr;
            end
            if (bus_if.queue_flush) flush_cnt++;
            if (done) begin
                done_cnt++;
                check("busy_low_with_done", 64'(busy), 64'd0);
            end
        end
    end

    // ---------------- DDR read-data responder ----------------
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (beats_left > 0) begin
                bus_if.ddr_valid = 1'b1;
                bus_if.ddr_data  = mem_word(beat_addr);
                beat_addr        = beat_addr + 32'd8;
                beats_left--;
            end else if (inject_valid) begin
                bus_if.ddr_valid = 1'b1;
                bus_if.ddr_data  = 64'hDEAD_BEEF_0BAD_F00D;
            end else begin
                bus_if.ddr_valid = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_start(input logic [31:0] b, input logic [15:0] n);
        @(posedge clock);
        #1;
        base_addr = b;
        num_words = n;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start     = 1'b0;
    endtask

    task automatic push_expect(input logic [31:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mem_word(b + 32'(i * 8)));
        end
    endtask

    task automatic wait_done(input string name, input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 2000) begin
            @(negedge clock);
            #1;
            n++;
        end
        repeat (3) @(negedge clock);
        #1;
        check(name, 64'(done_cnt), 64'(target));
    endtask

    task automatic end_of_test(input string name);
        check({name, "_exp_beats_left"}, 64'(exp_q.size()), 64'd0);
        check({name, "_exp_reqs_left"}, 64'(exp_req_q.size()), 64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin
        int d0, e0, a0, r0, f0, n, gap;
        logic [31:0] cap_addr;
        logic [7:0]  cap_len;

        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_words = '0;
        bus_if.ddr_wait_req = 1'b0;
        bus_if.ddr_valid    = 1'b0;
        bus_if.ddr_data     = '0;
        bus_if.queue_count  = '0;

        repeat (3) @(posedge clock);
        #1;
        check_outputs_zero("reset");
        reset_n = 1'b1;

        // T1: 32 beats from 0x1000, queue always drained
        d0 = done_cnt; e0 = enq_seen; a0 = acc_cnt;
        exp_req_q.push_back({32'h0000_1000, 8'd16});
        exp_req_q.push_back({32'h0000_1080, 8'd16});
        push_expect(32'h0000_1000, 32);
        run_start(32'h0000_1000, 16'd32);
        wait_done("t1_done_once", d0 + 1);
        check("t1_enq_count", 64'(enq_seen - e0), 64'd32);
        check("t1_accepts", 64'(acc_cnt - a0), 64'd2);
        end_of_test("t1");

        // T2: 20 beats -> 16 + final partial burst of 4
        d0 = done_cnt; e0 = enq_seen;
        exp_req_q.push_back({32'h0000_2000, 8'd16});
        exp_req_q.push_back({32'h0000_2080, 8'd4});
        push_expect(32'h0000_2000, 20);
        run_start(32'h0000_2000, 16'd20);
        wait_done("t2_done_once", d0 + 1);
        check("t2_enq_count", 64'(enq_seen - e0), 64'd20);
        end_of_test("t2");

        // T3: queue nearly full stalls CHECK; in-flight enqueue counts as used
        d0 = done_cnt; r0 = rd_cycles; e0 = enq_seen;
        bus_if.queue_count = 6'd20;
        exp_req_q.push_back({32'h0000_3000, 8'd16});
        exp_req_q.push_back({32'h0000_3080, 8'd16});
        push_expect(32'h0000_3000, 32);
        run_start(32'h0000_3000, 16'd32);
        repeat (8) @(posedge clock);
        #1;
        check("t3_no_rd_at_20", 64'(rd_cycles - r0), 64'd0);
        check("t3_busy_in_check", 64'(busy), 64'd1);
        bus_if.queue_count = 6'd17;
        repeat (4) @(posedge clock);
        #1;
        check("t3_no_rd_at_17", 64'(rd_cycles - r0), 64'd0);
        bus_if.queue_count = 6'd16;
        n = 0;
        while (enq_seen - e0 < 16 && n < 200) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("t3_first_burst_beats", 64'(enq_seen - e0), 64'd16);
        gap = 0;
        while (!bus_if.ddr_rd && gap < 20) begin
            @(negedge clock);
            #1;
            gap++;
        end
        check("t3_rd_gap_after_last_beat", 64'(gap), 64'd2);
        wait_done("t3_done_once", d0 + 1);
        bus_if.queue_count = 6'd0;
        end_of_test("t3");

        // T4: wait_req stall with address wrap (0xFFFFFF80 + 16 beats -> 0x0)
        d0 = done_cnt; a0 = acc_cnt;
        bus_if.ddr_wait_req = 1'b1;
        exp_req_q.push_back({32'hFFFF_FF80, 8'd16});
        exp_req_q.push_back({32'h0000_0000, 8'd8});
        push_expect(32'hFFFF_FF80, 24);
        run_start(32'hFFFF_FF80, 16'd24);
        n = 0;
        while (!bus_if.ddr_rd && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("t4_rd_seen", 64'(bus_if.ddr_rd), 64'd1);
        cap_addr = bus_if.ddr_addr;
        cap_len  = bus_if.ddr_burst_length;
        for (int k = 0; k < 5; k++) begin
            check("t4_stall_rd", 64'(bus_if.ddr_rd), 64'd1);
            check("t4_stall_addr", 64'(bus_if.ddr_addr), 64'h0000_0000_FFFF_FF80);
            check("t4_stall_len", 64'(bus_if.ddr_burst_length), 64'd16);
            check("t4_stable", {24'd0, bus_if.ddr_addr, bus_if.ddr_burst_length},
                  {24'd0, cap_addr, cap_len});
            @(negedge clock);
            #1;
        end
        @(posedge clock);
        #1;
        bus_if.ddr_wait_req = 1'b0;
        wait_done("t4_done_once", d0 + 1);
        check("t4_accepts", 64'(acc_cnt - a0), 64'd2);
        end_of_test("t4");

        // T5: num=0 -> flush then done, no request; start while busy ignored;
        // stray ddr_valid in IDLE is not enqueued
        d0 = done_cnt; r0 = rd_cycles; f0 = flush_cnt; e0 = enq_seen;
        @(posedge clock);
        #1;
        base_addr = 32'h0000_5000;
        num_words = 16'd0;
        start     = 1'b1;
        @(posedge clock);
        #1;
        base_addr = 32'h0000_9000;
        num_words = 16'd8;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done("t5_done_once", d0 + 1);
        check("t5_flush_once", 64'(flush_cnt - f0), 64'd1);
        check("t5_no_rd", 64'(rd_cycles - r0), 64'd0);
        inject_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        inject_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("t5_no_enq", 64'(enq_seen - e0), 64'd0);
        check("t5_idle", 64'(busy), 64'd0);

        // T6: reset in the middle of a burst, then a fresh transfer
        d0 = done_cnt; e0 = enq_seen;
        exp_req_q.push_back({32'h0000_6000, 8'd16});
        push_expect(32'h0000_6000, 16);
        run_start(32'h0000_6000, 16'd16);
        n = 0;
        while (enq_seen - e0 < 7 && n < 200) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("t6_beats_before_reset", 64'(enq_seen - e0), 64'd7);
        reset_n = 1'b0;
        beats_left = 0;
        exp_q.delete();
        exp_req_q.delete();
        #1;
        check_outputs_zero("t6_in_reset");
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("t6_idle_after_reset", 64'({busy, state_dbg}), 64'd0);
        check("t6_no_done", 64'(done_cnt), 64'(d0));
        d0 = done_cnt; e0 = enq_seen;
        exp_req_q.push_back({32'h0000_7000, 8'd4});
        push_expect(32'h0000_7000, 4);
        run_start(32'h0000_7000, 16'd4);
        wait_done("t6_restart_done", d0 + 1);
        check("t6_restart_enq", 64'(enq_seen - e0), 64'd4);
        end_of_test("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
